// File: rtl/digclk_pkg.sv
// digclk_pkg
//   Shared types and helpers for the digital_clock_mux block.
//   - state_t   : mode FSM states, encoded one-hot so the state register
//                 doubles as the LED output
//   - SEG_DASH / SEG_BLANK : fixed segment patterns
//   - bcd_to_seg: BCD digit to {dp,g..a} pattern, active-high
//   - bcd_inc / bcd_dec : two-digit BCD step with wrap at 0 / vmax
package digclk_pkg;

    typedef enum logic [4:0] {
        ST_RUN   = 5'b00001,
        ST_PAUSE = 5'b00010,
        ST_SET_S = 5'b00100,
        ST_SET_M = 5'b01000,
        ST_SET_H = 5'b10000
    } state_t;

    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0:    r = 8'h3f;
            4'd1:    r = 8'h06;
            4'd2:    r = 8'h5b;
            4'd3:    r = 8'h4f;
            4'd4:    r = 8'h66;
            4'd5:    r = 8'h6d;
            4'd6:    r = 8'h7d;
            4'd7:    r = 8'h07;
            4'd8:    r = 8'h7f;
            4'd9:    r = 8'h6f;
            default: r = SEG_BLANK;
        endcase
        return r;
    endfunction

    // v and vmax are {tens, ones} BCD; the result wraps vmax -> 0
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == vmax)
            r = 8'h00;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // wraps 0 -> vmax
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] vmax);
        logic [7:0] r;
        if (v == 8'h00)
            r = vmax;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/digclk_if.sv
// digclk_if
//   Board-side pins of the clock block.
//   btn_add/btn_sub/btn_stop/btn_mode : push-buttons, active-low, asynchronous
//   sel : digit select (7 = rightmost)
//   seg : segment pattern {dp,g..a}, active-high
//   led : one-hot mode indication [0]RUN [1]PAUSE [2]SET_S [3]SET_M [4]SET_H
//   master = board/stimulus side, slave = clock block
interface digclk_if;
    logic       btn_add;
    logic       btn_sub;
    logic       btn_stop;
    logic       btn_mode;
    logic [2:0] sel;
    logic [7:0] seg;
    logic [4:0] led;

    modport master (
        output btn_add, btn_sub, btn_stop, btn_mode,
        input  sel, seg, led
    );

    modport slave (
        input  btn_add, btn_sub, btn_stop, btn_mode,
        output sel, seg, led
    );
endinterface

// File: rtl/digclk_btn_debounce.sv
// btn_debounce
//   Two-flop synchroniser, debounce counter and press-pulse generator for
//   one active-low push-button.
//   Ports: clk, res (sync, active-high), btn_n (raw button, active-low),
//          press (one-cycle pulse on an accepted press)
//   A new level is accepted once the synchronised input has differed from
//   the accepted level for DEBOUNCE_CYC consecutive cycles. Reset returns
//   everything to "released", so a button held through reset is not seen
//   as a press as long as it is let go before reset is removed.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  logic clk,
    input  logic res,
    input  logic btn_n,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (res) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= btn_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync_2;
                cnt   <= '0;
                press <= ~sync_2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/digital_clock_mux.sv
// digital_clock_mux
//   HH-MM-SS clock with debounced buttons, run/pause/set mode FSM and an
//   8-digit multiplexed 7-segment driver.
//   Ports: clk (system clock), res (sync reset, active-high),
//          pins (digclk_if.slave: buttons in, sel/seg/led out)
//   Build option: define DIGCLK_BLINK_EN to blink the field being set
//   (blank during the second half of each TICKS_PER_SEC period).
module digital_clock_mux
    import digclk_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1000,
    parameter int SCAN_DIV      = 1,
    parameter int DEBOUNCE_CYC  = 20,
    parameter int HOUR_MOD      = 24
) (
    input logic     clk,
    input logic     res,
    digclk_if.slave pins
);
    localparam int PS_W = $clog2(TICKS_PER_SEC + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
    localparam int SD_W = $clog2(SCAN_DIV + 1);
    localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);
    localparam logic [7:0] MS_MAX = 8'h59;
    localparam logic [7:0] HR_MAX = 8'((((HOUR_MOD - 1) / 10) << 4) | ((HOUR_MOD - 1) % 10));

    logic add_p, sub_p, stop_p, mode_p;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_add  (.clk(clk), .res(res), .btn_n(pins.btn_add),  .press(add_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sub  (.clk(clk), .res(res), .btn_n(pins.btn_sub),  .press(sub_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (.clk(clk), .res(res), .btn_n(pins.btn_stop), .press(stop_p));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (.clk(clk), .res(res), .btn_n(pins.btn_mode), .press(mode_p));

    // one action per cycle: stop > mode > add/sub; add+sub together cancel
    logic do_stop, do_mode, do_add, do_sub;
    assign do_stop = stop_p;
    assign do_mode = mode_p & ~stop_p;
    assign do_add  = add_p & ~sub_p & ~stop_p & ~mode_p;
    assign do_sub  = sub_p & ~add_p & ~stop_p & ~mode_p;

    // state | meaning
    // RUN   | time advances; only stop is honoured
    // PAUSE | time frozen; stop resumes, mode enters setting
    // SET_S | add/sub adjust seconds
    // SET_M | add/sub adjust minutes
    // SET_H | add/sub adjust hours
    state_t state;

    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (do_stop) state <= ST_PAUSE;
                ST_PAUSE: if (do_stop) state <= ST_RUN;   else if (do_mode) state <= ST_SET_S;
                ST_SET_S: if (do_stop) state <= ST_RUN;   else if (do_mode) state <= ST_SET_M;
                ST_SET_M: if (do_stop) state <= ST_RUN;   else if (do_mode) state <= ST_SET_H;
                ST_SET_H: if (do_stop) state <= ST_RUN;   else if (do_mode) state <= ST_SET_S;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // one-hot encoding makes the state register the LED driver directly
    assign pins.led = state;

    logic [PS_W-1:0] ps;
    logic [7:0]      sec_r, min_r, hour_r;

    always_ff @(posedge clk) begin
        if (res) begin
            ps     <= '0;
            sec_r  <= 8'h00;
            min_r  <= 8'h00;
            hour_r <= 8'h00;
        end else if (state == ST_RUN) begin
            if (ps == PS_LAST) begin
                ps    <= '0;
                sec_r <= bcd_inc(sec_r, MS_MAX);
                if (sec_r == MS_MAX) begin
                    min_r <= bcd_inc(min_r, MS_MAX);
                    if (min_r == MS_MAX)
                        hour_r <= bcd_inc(hour_r, HR_MAX);
                end
            end else begin
                ps <= ps + 1'b1;
            end
        end else begin
            // manual adjust never carries; touching seconds restarts the second
            case (state)
                ST_SET_S: begin
                    if (do_add) begin
                        sec_r <= bcd_inc(sec_r, MS_MAX);
                        ps    <= '0;
                    end else if (do_sub) begin
                        sec_r <= bcd_dec(sec_r, MS_MAX);
                        ps    <= '0;
                    end
                end
                ST_SET_M: begin
                    if (do_add)      min_r <= bcd_inc(min_r, MS_MAX);
                    else if (do_sub) min_r <= bcd_dec(min_r, MS_MAX);
                end
                ST_SET_H: begin
                    if (do_add)      hour_r <= bcd_inc(hour_r, HR_MAX);
                    else if (do_sub) hour_r <= bcd_dec(hour_r, HR_MAX);
                end
                default: ;
            endcase
        end
    end

    logic [SD_W-1:0] scan_cnt;
    logic [2:0]      slot;
    logic [2:0]      sel_r;
    logic [7:0]      seg_r;
    logic [7:0]      slot_seg;
    logic            blank;

    // slot k shows on sel 7-k: s1 s10 - m1 m10 - h1 h10
    always_comb begin
        slot_seg = SEG_DASH;
        case (slot)
            3'd0:    slot_seg = bcd_to_seg(sec_r[3:0]);
            3'd1:    slot_seg = bcd_to_seg(sec_r[7:4]);
            3'd3:    slot_seg = bcd_to_seg(min_r[3:0]);
            3'd4:    slot_seg = bcd_to_seg(min_r[7:4]);
            3'd6:    slot_seg = bcd_to_seg(hour_r[3:0]);
            3'd7:    slot_seg = bcd_to_seg(hour_r[7:4]);
            default: slot_seg = SEG_DASH;
        endcase
    end

`ifdef DIGCLK_BLINK_EN
    logic [PS_W-1:0] blink_cnt;
    logic            slot_in_field;

    always_ff @(posedge clk) begin
        if (res)
            blink_cnt <= '0;
        else if (blink_cnt == PS_LAST)
            blink_cnt <= '0;
        else
            blink_cnt <= blink_cnt + 1'b1;
    end

    always_comb begin
        slot_in_field = 1'b0;
        case (slot)
            3'd0, 3'd1: slot_in_field = (state == ST_SET_S);
            3'd3, 3'd4: slot_in_field = (state == ST_SET_M);
            3'd6, 3'd7: slot_in_field = (state == ST_SET_H);
            default:    slot_in_field = 1'b0;
        endcase
    end

    assign blank = slot_in_field && (blink_cnt >= PS_W'(TICKS_PER_SEC / 2));
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (res) begin
            scan_cnt <= '0;
            slot     <= 3'd0;
            sel_r    <= 3'd7;
            seg_r    <= SEG_BLANK;
        end else begin
            if (scan_cnt == SD_LAST) begin
                scan_cnt <= '0;
                slot     <= slot + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            sel_r <= ~slot;
            seg_r <= blank ? SEG_BLANK : slot_seg;
        end
    end

    assign pins.sel = sel_r;
    assign pins.seg = seg_r;
endmodule

// File: tb/tb_digital_clock_mux.sv
module tb_digital_clock_mux;

    localparam logic [3:0] B_STOP = 4'b0001;
    localparam logic [3:0] B_MODE = 4'b0010;
    localparam logic [3:0] B_ADD  = 4'b0100;
    localparam logic [3:0] B_SUB  = 4'b1000;

    localparam logic [4:0] L_RUN  = 5'b00001;
    localparam logic [4:0] L_PAU  = 5'b00010;
    localparam logic [4:0] L_SS   = 5'b00100;
    localparam logic [4:0] L_SM   = 5'b01000;
    localparam logic [4:0] L_SH   = 5'b10000;

    logic clk = 1'b0;
    logic res = 1'b1;

    digclk_if pins();

    digital_clock_mux #(
        .TICKS_PER_SEC(4),
        .SCAN_DIV(1),
        .DEBOUNCE_CYC(3),
        .HOUR_MOD(24)
    ) dut (
        .clk(clk),
        .res(res),
        .pins(pins)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  btns;
        int          hold;
        int          n;
        logic [4:0]  led;
        logic [23:0] hms;
    } step_t;

    step_t steps[22];

    typedef struct {
        logic [2:0] sel;
        logic [7:0] seg;
    } scan_t;

    scan_t scan_exp[8];

    function automatic logic [7:0] exp_seg(input logic [3:0] d);
        logic [7:0] r;
        case (d)
            4'd0: r = 8'h3f; 4'd1: r = 8'h06; 4'd2: r = 8'h5b; 4'd3: r = 8'h4f;
            4'd4: r = 8'h66; 4'd5: r = 8'h6d; 4'd6: r = 8'h7d; 4'd7: r = 8'h07;
            4'd8: r = 8'h7f; 4'd9: r = 8'h6f; default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [23:0] dut_time();
        return {dut.hour_r, dut.min_r, dut.sec_r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] m);
        pins.btn_stop = ~m[0];
        pins.btn_mode = ~m[1];
        pins.btn_add  = ~m[2];
        pins.btn_sub  = ~m[3];
    endtask

    task automatic press(input logic [3:0] m, input int hold);
        set_btns(m);
        repeat (hold) @(negedge clk);
        set_btns(4'b0000);
        repeat (12) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
    endtask

    // reads one full scan starting at sel=7 and compares against the time
    task automatic check_frame(input string name, input logic [23:0] hms);
        logic [7:0]  ex [8];
        logic [10:0] got_bad;
        logic [10:0] exp_bad;
        bit          ok;
        int          w;
        ex[0] = exp_seg(hms[3:0]);   ex[1] = exp_seg(hms[7:4]);   ex[2] = 8'h40;
        ex[3] = exp_seg(hms[11:8]);  ex[4] = exp_seg(hms[15:12]); ex[5] = 8'h40;
        ex[6] = exp_seg(hms[19:16]); ex[7] = exp_seg(hms[23:20]);
        w = 0;
        while (pins.sel !== 3'd7 && w < 20) begin
            @(negedge clk);
            w++;
        end
        ok = 1'b1;
        got_bad = '0;
        exp_bad = '0;
        for (int k = 0; k < 8; k++) begin
            if (ok && (pins.sel !== 3'(7 - k) || pins.seg !== ex[k])) begin
                ok = 1'b0;
                got_bad = {pins.sel, pins.seg};
                exp_bad = {3'(7 - k), ex[k]};
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s frame %06h: got sel/seg %0h expected %0h", name, hms, got_bad, exp_bad);
        end
    endtask

    task automatic run_steps(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            for (int p = 0; p < steps[i].n; p++)
                press(steps[i].btns, steps[i].hold);
            check($sformatf("step%0d led", i), 32'(pins.led), 32'(steps[i].led));
            check_frame($sformatf("step%0d", i), steps[i].hms);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int pulses;

        // each block starts right after reset release, so the stop press
        // lands in second 1 regardless of the exact debounce latency
        steps[0]  = '{B_STOP,        10, 1,  L_PAU, 24'h000001};
        steps[1]  = '{B_MODE,        10, 1,  L_SS,  24'h000001};
        steps[2]  = '{B_SUB,         10, 1,  L_SS,  24'h000000};
        steps[3]  = '{B_SUB,         10, 1,  L_SS,  24'h000059};
        steps[4]  = '{B_ADD,         10, 1,  L_SS,  24'h000000};
        steps[5]  = '{B_SUB,         10, 1,  L_SS,  24'h000059};
        steps[6]  = '{B_MODE,        10, 1,  L_SM,  24'h000059};
        steps[7]  = '{B_SUB,         10, 1,  L_SM,  24'h005959};
        steps[8]  = '{B_MODE,        10, 1,  L_SH,  24'h005959};
        steps[9]  = '{B_SUB,         10, 1,  L_SH,  24'h235959};
        steps[10] = '{B_STOP,        10, 1,  L_PAU, 24'h000001};
        steps[11] = '{B_ADD,         10, 1,  L_PAU, 24'h000001};
        steps[12] = '{B_MODE,        10, 1,  L_SS,  24'h000001};
        steps[13] = '{B_ADD,          2, 1,  L_SS,  24'h000001};
        steps[14] = '{B_ADD,         10, 1,  L_SS,  24'h000002};
        steps[15] = '{B_ADD | B_SUB, 10, 1,  L_SS,  24'h000002};
        steps[16] = '{B_MODE | B_ADD,10, 1,  L_SM,  24'h000002};
        steps[17] = '{B_SUB,         10, 26, L_SM,  24'h003402};
        steps[18] = '{B_MODE,        10, 1,  L_SH,  24'h003402};
        steps[19] = '{B_ADD,         10, 12, L_SH,  24'h123402};
        steps[20] = '{B_MODE,        10, 1,  L_SS,  24'h123402};
        steps[21] = '{B_SUB,         10, 6,  L_SS,  24'h123456};

        scan_exp[0] = '{3'd7, 8'h7d}; scan_exp[1] = '{3'd6, 8'h6d};
        scan_exp[2] = '{3'd5, 8'h40}; scan_exp[3] = '{3'd4, 8'h66};
        scan_exp[4] = '{3'd3, 8'h4f}; scan_exp[5] = '{3'd2, 8'h40};
        scan_exp[6] = '{3'd1, 8'h5b}; scan_exp[7] = '{3'd0, 8'h06};

        set_btns(4'b0000);
        res = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset led", 32'(pins.led), 32'(L_RUN));
        check("reset sel", 32'(pins.sel), 32'd7);
        check("reset seg", 32'(pins.seg), 32'h00);
        check("reset time", 32'(dut_time()), 32'h000000);
        res = 1'b0;

        // free run: 4 cycles per second
        repeat (239) @(posedge clk);
        #1 check("run 239 cycles", 32'(dut_time()), 32'h000059);
        @(posedge clk);
        #1 check("run 240 cycles", 32'(dut_time()), 32'h000100);
        check("run led", 32'(pins.led), 32'(L_RUN));

        do_reset();
        run_steps(0, 9);

        // resume from 23:59:59 with a cleared prescaler: wraps after 4 cycles
        set_btns(B_STOP);
        w = 0;
        while (pins.led !== L_RUN && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("resume led", 32'(pins.led), 32'(L_RUN));
        set_btns(4'b0000);
        repeat (3) @(posedge clk);
        #1 check("before wrap", 32'(dut_time()), 32'h235959);
        @(posedge clk);
        #1 check("day wrap", 32'(dut_time()), 32'h000000);

        do_reset();
        run_steps(10, 21);

        // scan order at 12:34:56
        w = 0;
        while (pins.sel !== 3'd7 && w < 20) begin
            @(negedge clk);
            w++;
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("scan slot %0d", k), 32'({pins.sel, pins.seg}),
                  32'({scan_exp[k].sel, scan_exp[k].seg}));
            @(negedge clk);
        end

        press(B_MODE, 10);
        check("to SET_M led", 32'(pins.led), 32'(L_SM));

        // reset mid-adjust with buttons held
        set_btns(B_ADD | B_SUB);
        repeat (8) @(negedge clk);
        check("add+sub held", 32'(dut_time()), 32'h123456);
        res = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset time", 32'(dut_time()), 32'h000000);
        check("mid reset led", 32'(pins.led), 32'(L_RUN));
        check("mid reset sel", 32'(pins.sel), 32'd7);
        check("mid reset seg", 32'(pins.seg), 32'h00);
        @(negedge clk);
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        res = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            pulses += int'(dut.add_p) + int'(dut.sub_p) + int'(dut.stop_p) + int'(dut.mode_p);
        end
        check("no spurious press", 32'(pulses), 32'd0);
        check("post reset led", 32'(pins.led), 32'(L_RUN));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
